// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit with HI/LO architectural registers.
// A single (WIDTH+1)-bit adder/subtractor is shared between shift-add multiply
// and restoring divide. Operation: one latch cycle, WIDTH step cycles,
// then one sign-fix cycle.
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       calc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       calc_q, calc_d;
  // opnd holds the multiplicand (multiply) or the divisor (divide).
  logic [WIDTH-1:0] opnd_q, opnd_d;
  // acc holds the product upper half or the partial remainder.
  logic [WIDTH-1:0] acc_q, acc_d;
  // low holds the multiplier/product lower half or the dividend/quotient.
  logic [WIDTH-1:0] low_q, low_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  logic [WIDTH:0]     add_x, add_y, add_s;
  logic [2*WIDTH-1:0] prod_res;
  logic [WIDTH-1:0]   quot_res, rem_res;
  logic [WIDTH-1:0]   res_hi, res_lo;

  // Operand magnitudes and signs; signs only count for the signed ops.
  always_comb begin
    a_neg = calc[0] & a[WIDTH-1];
    b_neg = calc[0] & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  // Shared adder: multiply adds the multiplicand when the multiplier LSB is
  // set; divide subtracts the divisor from the shifted partial remainder.
  always_comb begin
    if (calc_q[1]) begin
      add_x = {acc_q, low_q[WIDTH-1]};
      add_y = {1'b0, opnd_q};
    end else begin
      add_x = {1'b0, acc_q};
      add_y = low_q[0] ? {1'b0, opnd_q} : '0;
    end
    add_s = add_x + (calc_q[1] ? ~add_y : add_y) + {{WIDTH{1'b0}}, calc_q[1]};
  end

  // Sign correction of the raw magnitudes at the end of an operation. With a
  // zero divisor the remainder register has shifted in the whole dividend
  // magnitude, so the sign-corrected remainder reproduces a as given.
  always_comb begin
    prod_res = {acc_q, low_q};
    if (sign_a_q ^ sign_b_q) prod_res = -prod_res;
    quot_res = (sign_a_q ^ sign_b_q) ? -low_q : low_q;
    rem_res  = sign_a_q ? -acc_q : acc_q;
    if (calc_q[1]) begin
      res_hi = rem_res;
      res_lo = zero_q ? '1 : quot_res;
    end else begin
      res_hi = prod_res[2*WIDTH-1:WIDTH];
      res_lo = prod_res[WIDTH-1:0];
    end
  end

  // Next-state logic for the controller, datapath and architectural registers.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    calc_d   = calc_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    low_d    = low_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    zero_d   = zero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start && !cancel) begin
          state_d  = RUN;
          cnt_d    = CNT_W'(WIDTH);
          calc_d   = calc;
          sign_a_d = a_neg;
          sign_b_d = b_neg;
          zero_d   = (b == '0);
          acc_d    = '0;
          if (calc[1]) begin
            opnd_d = b_mag;
            low_d  = a_mag;
          end else begin
            opnd_d = a_mag;
            low_d  = b_mag;
          end
        end
      end
      RUN: begin
        if (cancel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          if (calc_q[1]) begin
            acc_d = add_s[WIDTH] ? add_x[WIDTH-1:0] : add_s[WIDTH-1:0];
            low_d = {low_q[WIDTH-2:0], ~add_s[WIDTH]};
          end else begin
            acc_d = add_s[WIDTH:1];
            low_d = {add_s[0], low_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!cancel) begin
          hi_d   = res_hi;
          lo_d   = res_lo;
          done_d = 1'b1;
          if (calc_q[1]) dz_d = zero_q;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State registers; reset forces IDLE and clears all visible state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      calc_q   <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      low_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      zero_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      calc_q   <= calc_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      low_q    <= low_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      zero_q   <= zero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dz_q     <= dz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dz   = dz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
